// File: rtl/sample_pos_sequencer.sv
// Purpose : per-voice phase accumulator sweeping a position RAM once per sample tick.
// Latency : first pos_valid one cycle after the READ that follows the accepting tick; sweep = 2*NUM_VOICES cycles.
// Backpr. : none; ticks arriving while busy are dropped and flagged on tick_overrun.
//
// Ports:
//   clk, reset_n        - clock (rising edge), asynchronous active-low reset
//   sample_tick         - starts one sweep over all voices when idle
//   voice_inc           - increment for the voice on voice_idx, same cycle
//   voice_idx           - voice currently processed (also the RAM address)
//   ram_addr/din/we     - position RAM write port / address
//   ram_dout            - asynchronous read data for ram_addr
//   pos_out, pos_valid  - updated position and its one-cycle strobe
//   busy                - high while clearing or sweeping
//   tick_overrun        - one-cycle pulse after a dropped tick
module sample_pos_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_VOICES = 8,
    parameter int WAVE_LEN   = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic [DATA_WIDTH-1:0] voice_inc,
    output logic [ADDR_WIDTH-1:0] voice_idx,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] pos_out,
    output logic                  pos_valid,
    output logic                  busy,
    output logic                  tick_overrun
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH:0]   LP_WAVE = (DATA_WIDTH+1)'(WAVE_LEN);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(NUM_VOICES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_next;
    logic [DATA_WIDTH-1:0] w_next_nxt;
    logic                  r_overrun;
    logic                  w_busy;
    logic                  w_last;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_wrapped;

    // One extra bit so the sum cannot overflow before the wrap compare.
    assign w_sum     = {1'b0, ram_dout} + {1'b0, voice_inc};
    // In-contract operands are < WAVE_LEN, so one subtraction suffices.
    assign w_wrapped = (w_sum >= LP_WAVE) ? DATA_WIDTH'(w_sum - LP_WAVE) : DATA_WIDTH'(w_sum);
    assign w_last    = (r_idx == LP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CLEAR;
            r_idx     <= '0;
            r_next    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_next    <= w_next_nxt;
            // A tick seen while busy is never acted on; only flagged.
            r_overrun <= sample_tick & w_busy;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_next_nxt  = r_next;
        ram_we      = 1'b0;
        ram_din     = '0;
        pos_valid   = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_CLEAR: begin
                ram_we = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                w_busy = 1'b0;
                if (sample_tick) begin
                    w_state_nxt = ST_READ;
                    w_idx_nxt   = '0;
                end
            end
            ST_READ: begin
                w_next_nxt  = w_wrapped;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_din   = r_next;
                pos_valid = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = ST_READ;
                    w_idx_nxt   = r_idx + ADDR_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // r_next only changes at the end of READ, so it also serves as the
    // held pos_out between WRITE cycles.
    assign voice_idx    = r_idx;
    assign ram_addr     = r_idx;
    assign pos_out      = r_next;
    assign busy         = w_busy;
    assign tick_overrun = r_overrun;

endmodule

// File: tb/tb_sample_pos_sequencer.sv
module tb_sample_pos_sequencer;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NV = 4;
    localparam int WL = 1000;

    logic          clk;
    logic          reset_n;
    logic          sample_tick;
    logic [DW-1:0] voice_inc;
    logic [AW-1:0] voice_idx;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] pos_out;
    logic          pos_valid;
    logic          busy;
    logic          tick_overrun;

    sample_pos_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_VOICES(NV), .WAVE_LEN(WL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .voice_inc(voice_inc),
        .voice_idx(voice_idx), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .pos_out(pos_out), .pos_valid(pos_valid), .busy(busy),
        .tick_overrun(tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position RAM model with a bench backdoor write port.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_dat;
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_dat;
        else if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    logic [DW-1:0] inc_tab [0:(1<<AW)-1];
    assign voice_inc = inc_tab[voice_idx];

    typedef struct { int idx; int pos; } exp_t;
    exp_t q[$];
    int   ref_pos[NV];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // Reference model: each voice advances by its increment modulo WAVE_LEN.
    task automatic push_expected();
        for (int v = 0; v < NV; v++) begin
            ref_pos[v] = (ref_pos[v] + int'(inc_tab[v])) % WL;
            q.push_back('{v, ref_pos[v]});
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (pos_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected pos_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("voice_idx", int'(voice_idx), e.idx);
                chk("pos_out", int'(pos_out), e.pos);
                chk("ram write mirrors pos", int'(ram_we && ram_addr == voice_idx && ram_din == pos_out), 1);
            end
        end
    end

    task automatic bd_write(input int a, input int d);
        @(negedge clk);
        bd_en   = 1'b1;
        bd_addr = AW'(a);
        bd_dat  = DW'(d);
        @(negedge clk);
        bd_en   = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst voice_idx", int'(voice_idx), 0);
        chk("rst pos_out", int'(pos_out), 0);
        chk("rst pos_valid", int'(pos_valid), 0);
        chk("rst tick_overrun", int'(tick_overrun), 0);
        chk("rst busy", int'(busy), 1);
    endtask

    task automatic release_and_check_clear();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < NV; k++) begin
            if (k > 0) @(negedge clk);
            chk("clear we", int'(ram_we), 1);
            chk("clear din", int'(ram_din), 0);
            chk("clear addr", int'(ram_addr), k);
            chk("clear busy", int'(busy), 1);
        end
        @(negedge clk);
        chk("idle after clear busy", int'(busy), 0);
        chk("idle after clear we", int'(ram_we), 0);
        for (int v = 0; v < NV; v++) ref_pos[v] = 0;
    endtask

    // Called at a negedge with the DUT idle; inj[k] raises an extra tick
    // sampled on the k-th busy edge of the sweep.
    task automatic do_sweep(input logic [8:0] inj);
        int ov_exp;
        int ov_seen;
        ov_exp  = 0;
        ov_seen = 0;
        push_expected();
        sample_tick = 1'b1;
        for (int k = 1; k <= 2*NV; k++) begin
            @(negedge clk);
            sample_tick = inj[k];
            if (inj[k]) ov_exp++;
            chk("busy during sweep", int'(busy), 1);
            if (tick_overrun) ov_seen++;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        if (tick_overrun) ov_seen++;
        chk("busy after sweep", int'(busy), 0);
        chk("tick_overrun pulses", ov_seen, ov_exp);
        chk("scoreboard drained", q.size(), 0);
        chk("pos_out hold", int'(pos_out), ref_pos[NV-1]);
    endtask

    initial begin
        logic [8:0] inj;
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        bd_en       = 1'b0;
        bd_addr     = '0;
        bd_dat      = '0;
        for (int v = 0; v < NV; v++) inc_tab[v] = 16'd0;
        // Dirty the RAM so the clear pass is observable.
        for (int v = 0; v < NV; v++) bd_write(v, int'($urandom_range(1, WL-1)));
        #1;
        check_reset_outputs();
        release_and_check_clear();

        // Basic sweep from cleared positions.
        for (int v = 0; v < NV; v++) inc_tab[v] = 16'd100;
        do_sweep(9'b0);

        // Dropped ticks at sweep cycle 3 and on the final WRITE cycle.
        do_sweep(9'b1_0000_1000);

        // Wrap boundary.
        bd_write(0, 950);
        bd_write(1, 900);
        bd_write(2, 899);
        bd_write(3, 0);
        ref_pos[0] = 950; ref_pos[1] = 900; ref_pos[2] = 899; ref_pos[3] = 0;
        do_sweep(9'b0);

        // Back-to-back sweeps, increment 300 from zero.
        for (int v = 0; v < NV; v++) begin
            bd_write(v, 0);
            ref_pos[v] = 0;
            inc_tab[v] = 16'd300;
        end
        for (int s = 0; s < 4; s++) do_sweep(9'b0);

        // Randomized sweeps with random dropped ticks.
        for (int s = 0; s < 20; s++) begin
            for (int v = 0; v < NV; v++) inc_tab[v] = DW'($urandom_range(0, WL-1));
            inj = '0;
            for (int k = 1; k <= 8; k++) inj[k] = ($urandom_range(0, 3) == 0);
            do_sweep(inj);
        end

        // Reset during voice 2 READ abandons the sweep.
        for (int v = 0; v < NV; v++) inc_tab[v] = 16'd100;
        push_expected();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("voice before reset", int'(voice_idx), 2);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        chk("pending at reset", q.size(), 2);
        q.delete();
        repeat (2) @(negedge clk);
        release_and_check_clear();
        repeat (5) @(negedge clk);
        chk("busy idle no tick", int'(busy), 0);
        do_sweep(9'b0);

        for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < NV; v++) inc_tab[v] = DW'($urandom_range(0, WL-1));
            do_sweep(9'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sample_pos_sequencer.md
SAMPLE_POS_SEQUENCER -- requirements
Module: sample_pos_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10; position RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16; position word width.
REQ-003 SHALL have parameter NUM_VOICES, default 8; voices per sweep, range 1..2^ADDR_WIDTH.
REQ-004 SHALL have parameter WAVE_LEN, default 1024; wrap modulus, range 2..2^DATA_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port sample_tick, input, 1 bit; starts one sweep over all voices.
REQ-008 SHALL have port voice_inc, input, DATA_WIDTH; increment for the voice on voice_idx, valid the same cycle.
REQ-009 SHALL have port voice_idx, output, ADDR_WIDTH; voice being processed.
REQ-010 SHALL have port ram_addr, output, ADDR_WIDTH; address to the position RAM.
REQ-011 SHALL have port ram_din, output, DATA_WIDTH; write data to the position RAM.
REQ-012 SHALL have port ram_we, output, 1 bit; write enable to the position RAM.
REQ-013 SHALL have port ram_dout, input, DATA_WIDTH; asynchronous read data for ram_addr.
REQ-014 SHALL have port pos_out, output, DATA_WIDTH; updated position for downstream lookup.
REQ-015 SHALL have port pos_valid, output, 1 bit; one-cycle strobe qualifying pos_out and voice_idx.
REQ-016 SHALL have port busy, output, 1 bit; high in CLEAR, READ, WRITE.
REQ-017 SHALL have port tick_overrun, output, 1 bit; one-cycle pulse when a tick is dropped.

Function
REQ-018 SHALL implement states CLEAR, IDLE, READ, WRITE; ram_addr SHALL equal voice_idx in every state.
REQ-019 CLEAR SHALL assert ram_we=1 and ram_din=0 at voice_idx 0..NUM_VOICES-1, one address per cycle, then enter IDLE.
REQ-020 IDLE SHALL hold ram_we=0 and, on sample_tick=1 at a clock edge, enter READ with voice_idx=0.
REQ-021 READ SHALL hold ram_we=0, compute sum=ram_dout+voice_inc at DATA_WIDTH+1 bits, register next=(sum>=WAVE_LEN)?sum-WAVE_LEN:sum, and enter WRITE.
REQ-022 WRITE SHALL drive ram_we=1, ram_din=next, pos_out=next, pos_valid=1 for exactly one cycle.
REQ-023 From WRITE, the block SHALL enter READ with voice_idx+1, or IDLE with voice_idx=0 when voice_idx=NUM_VOICES-1.
REQ-024 A sweep SHALL take exactly 2*NUM_VOICES cycles, and the first pos_valid SHALL occur 2 cycles after the accepting tick edge.
REQ-025 sample_tick=1 at an edge while busy=1 (including the last WRITE cycle and all of CLEAR) SHALL be ignored, and tick_overrun SHALL pulse the following cycle.
REQ-026 A dropped tick SHALL NOT alter the in-progress sweep or CLEAR.
REQ-027 pos_out SHALL hold its last value outside WRITE; pos_valid SHALL be 0 outside WRITE.
REQ-028 voice_inc>=WAVE_LEN and stored positions>=WAVE_LEN are out of contract; no behaviour is required for them.

Reset
REQ-029 reset_n=0 SHALL immediately force state CLEAR, voice_idx=0, next=0, pos_out=0, pos_valid=0, tick_overrun=0, and busy=1.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep and re-run the full CLEAR after release.

Verification
REQ-031 Reset release, NUM_VOICES=4 -> ram_we=1 with ram_din=0 at addr 0,1,2,3 on consecutive cycles, busy=1 for 4 cycles, then busy=0.
REQ-032 Tick with voice_inc=100 and all positions 0, WAVE_LEN=1000 -> 4 pos_valid pulses on alternate cycles, pos_out=100, voice_idx 0..3, busy=1 for 8 cycles.
REQ-033 Wrap boundary, WAVE_LEN=1000, voice_inc=100 -> stored 950 gives 50, 900 gives 0, 899 gives 999.
REQ-034 Tick during sweep cycle 3 and tick on the final WRITE cycle -> each pulses tick_overrun once, sweep output unchanged, block returns to IDLE.
REQ-035 Tick in IDLE accepted, then reset_n=0 during voice 2 READ -> outputs zero immediately, CLEAR reruns with addr 0..3, no further pos_valid until a new tick.
REQ-036 Back-to-back sweeps, WAVE_LEN=1000, voice_inc=300, positions starting at 0 -> pos_out per voice 300, 600, 900, 200 across four ticks.
